// File: rtl/vfr_pkg.sv
`default_nettype none
// ============================================================================
// vfr_pkg : shared types and constants for the VFR control-packet inserter
// Revision: 1.0
// ============================================================================
package vfr_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        SEND_BODY = 3'd2,
        PASS      = 3'd3,
        DROP      = 3'd4
    } vfr_state_e;

    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
    localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
    localparam int         CTRL_NIBBLES   = 9;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/st_skid_buffer.sv
`default_nettype none
// ============================================================================
// st_skid_buffer : two-entry Avalon-ST register slice carrying data/sop/eop
// Revision: 1.0
// ============================================================================
module st_skid_buffer #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop
);

    localparam int ENT_W = DATA_W + 2;

    logic [ENT_W-1:0] mem_q [2];
    logic [ENT_W-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    // Outputs are forced to zero when empty so stale entries never leak out.
    assign out_data = out_valid ? head[DATA_W-1:0] : '0;
    assign out_eop  = out_valid && head[DATA_W];
    assign out_sop  = out_valid && head[DATA_W+1];

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_sop, in_eop, in_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vfr_ctrl_packet_inserter.sv
`default_nettype none
// ============================================================================
// vfr_ctrl_packet_inserter : inserts a VIP control packet ahead of video frames
// Revision: 1.0
// ============================================================================
module vfr_ctrl_packet_inserter
    import vfr_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int ALWAYS_SEND      = 0,
    parameter int CHANGE_DETECT    = 1,
    parameter int DROP_INPUT_CTRL  = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic                                        dout_sop,
    output logic                                        dout_eop,
    input  logic                                        do_control_packet,
    input  logic [15:0]                                 width,
    input  logic [15:0]                                 height,
    input  logic [3:0]                                  interlaced,
    output logic                                        busy,
    output logic                                        ctrl_sent
);

    localparam int         DW        = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int         NBODY     = ceil_div(CTRL_NIBBLES, SYMBOLS_PER_BEAT);
    localparam logic [3:0] LAST_BEAT = 4'(NBODY - 1);

    vfr_state_e        state_q, state_d;
    logic              pending_q, pending_d;
    logic [35:0]       last_sent_q, last_sent_d;
    logic [35:0]       shadow_q, shadow_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;

    logic [35:0]       fmt;
    logic [3:0]        din_type;
    logic              hdr_entry;
    logic              pending_set;
    logic [NBODY*DW-1:0] body_all;
    logic [DW-1:0]     body_beat;

    logic              skid_valid, skid_ready, skid_sop, skid_eop;
    logic [DW-1:0]     skid_data;

    assign fmt      = {width, height, interlaced};
    assign din_type = din_data[3:0];
    assign busy     = (state_q != IDLE);

    // Nibble k lands at symbol offset k, which is beat k/SPB, symbol k%SPB.
    always_comb begin
        body_all = '0;
        for (int k = 0; k < CTRL_NIBBLES; k++) begin
            body_all[k*BITS_PER_SYMBOL +: 4] = shadow_q[35-4*k -: 4];
        end
    end

    assign body_beat = body_all[int'(beat_cnt_q)*DW +: DW];

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        shadow_d    = shadow_q;
        last_sent_d = last_sent_q;
        din_ready   = 1'b0;
        skid_valid  = 1'b0;
        skid_data   = '0;
        skid_sop    = 1'b0;
        skid_eop    = 1'b0;
        ctrl_sent   = 1'b0;

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    if (!din_sop) begin
                        state_d = DROP;
                    end else if (din_type == PKT_TYPE_VIDEO) begin
                        state_d = (pending_q || (ALWAYS_SEND != 0)) ? SEND_HDR : PASS;
                    end else if ((din_type == PKT_TYPE_CTRL) && (DROP_INPUT_CTRL != 0)) begin
                        state_d = DROP;
                    end else begin
                        state_d = PASS;
                    end
                end
            end
            SEND_HDR: begin
                skid_valid = 1'b1;
                skid_data  = DW'(PKT_TYPE_CTRL);
                skid_sop   = 1'b1;
                if (skid_ready) begin
                    state_d    = SEND_BODY;
                    beat_cnt_d = 4'd0;
                end
            end
            SEND_BODY: begin
                skid_valid = 1'b1;
                skid_data  = body_beat;
                skid_eop   = (beat_cnt_q == LAST_BEAT);
                if (skid_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        ctrl_sent  = 1'b1;
                        state_d    = PASS;
                        beat_cnt_d = 4'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end
            PASS: begin
                din_ready  = skid_ready;
                skid_valid = din_valid;
                skid_data  = din_data;
                skid_sop   = din_sop;
                skid_eop   = din_eop;
                if (din_valid && skid_ready && din_eop) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                din_ready = 1'b1;
                if (din_valid && din_eop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hdr_entry = (state_q == IDLE) && (state_d == SEND_HDR);
        if (hdr_entry) begin
            shadow_d    = fmt;
            last_sent_d = fmt;
        end

        // Compare against the value being captured so the capture cycle itself
        // does not re-arm pending.
        pending_set = do_control_packet || ((CHANGE_DETECT != 0) && (fmt != last_sent_d));
        if (pending_set) begin
            pending_d = 1'b1;
        end else if (hdr_entry) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= 1'b1;
            last_sent_q <= '0;
            shadow_q    <= '0;
            beat_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_sent_q <= last_sent_d;
            shadow_q    <= shadow_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    st_skid_buffer #(
        .DATA_W (DW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (skid_valid),
        .in_ready  (skid_ready),
        .in_data   (skid_data),
        .in_sop    (skid_sop),
        .in_eop    (skid_eop),
        .out_valid (dout_valid),
        .out_ready (dout_ready),
        .out_data  (dout_data),
        .out_sop   (dout_sop),
        .out_eop   (dout_eop)
    );

endmodule
`default_nettype wire

// File: tb/tb_vfr_ctrl_packet_inserter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vfr_ctrl_packet_inserter : randomized scoreboard bench for the inserter
// Revision: 1.0
// ============================================================================
module tb_vfr_ctrl_packet_inserter;

    localparam int BPS  = 8;
    localparam int SPB  = 3;
    localparam int DW   = BPS * SPB;
    localparam int NB   = (9 + SPB - 1) / SPB;
    localparam int DROP_CTRL = 1;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_ready, din_valid, din_sop, din_eop;
    logic [DW-1:0] din_data;
    logic          dout_ready, dout_valid, dout_sop, dout_eop;
    logic [DW-1:0] dout_data;
    logic          do_control_packet;
    logic [15:0]   width, height;
    logic [3:0]    interlaced;
    logic          busy, ctrl_sent;

    int    checks = 0;
    int    failures = 0;
    int    rdy_mode = 0;
    int    ctrl_pulses = 0;
    int    pulse_base = 0;
    int    exp_pulses = 0;
    int    rx_base = 0;
    beat_t rx_q[$];
    beat_t exp_q[$];

    // Behavioural model state: pending request and last format sent.
    logic        m_pending;
    logic [35:0] m_last;

    always #5 clk = ~clk;

    vfr_ctrl_packet_inserter #(
        .BITS_PER_SYMBOL  (BPS),
        .SYMBOLS_PER_BEAT (SPB),
        .ALWAYS_SEND      (0),
        .CHANGE_DETECT    (1),
        .DROP_INPUT_CTRL  (DROP_CTRL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .din_ready         (din_ready),
        .din_valid         (din_valid),
        .din_data          (din_data),
        .din_sop           (din_sop),
        .din_eop           (din_eop),
        .dout_ready        (dout_ready),
        .dout_valid        (dout_valid),
        .dout_data         (dout_data),
        .dout_sop          (dout_sop),
        .dout_eop          (dout_eop),
        .do_control_packet (do_control_packet),
        .width             (width),
        .height            (height),
        .interlaced        (interlaced),
        .busy              (busy),
        .ctrl_sent         (ctrl_sent)
    );

    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = ~dout_ready;
                2:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) rx_q.push_back({dout_sop, dout_eop, dout_data});
        if (!rst && ctrl_sent) ctrl_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] nib(input logic [35:0] f, input int k);
        return f[35-4*k -: 4];
    endfunction

    // Expected control packet: header beat then nibbles grouped SPB per beat.
    task automatic push_ctrl(input logic [35:0] f);
        logic [DW-1:0] d;
        exp_q.push_back({1'b1, 1'b0, DW'(4'hF)});
        for (int b = 0; b < NB; b++) begin
            d = '0;
            for (int s = 0; s < SPB; s++) begin
                if (b * SPB + s < 9) d = d | (DW'(nib(f, b * SPB + s)) << (s * BPS));
            end
            exp_q.push_back({1'b0, (b == NB - 1), d});
        end
        exp_pulses++;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_fmt(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
        width = w; height = h; interlaced = il;
        if ({w, h, il} != m_last) m_pending = 1'b1;
        repeat (2) tick();
    endtask

    task automatic request();
        do_control_packet = 1'b1;
        tick();
        do_control_packet = 1'b0;
        m_pending = 1'b1;
        tick();
    endtask

    task automatic send_pkt(input logic [3:0] typ, input int nbeats, input bit req_on_sop, input bit gaps);
        logic [DW-1:0] d;
        logic [35:0]   f;
        bit            done, first_rdy;
        int            waited;
        f = {width, height, interlaced};
        if (typ == 4'h0 && m_pending) begin
            push_ctrl(f);
            m_last    = f;
            m_pending = req_on_sop;
        end else if (req_on_sop) begin
            m_pending = 1'b1;
        end
        for (int i = 0; i < nbeats; i++) begin
            d = DW'($urandom);
            if (i == 0) d[3:0] = typ;
            if (gaps && $urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                tick();
            end
            din_valid = 1'b1; din_data = d;
            din_sop = (i == 0); din_eop = (i == nbeats - 1);
            if (i == 0) do_control_packet = req_on_sop;
            if (!(typ == 4'hF && DROP_CTRL != 0)) exp_q.push_back({din_sop, din_eop, d});
            waited = 0; done = 1'b0; first_rdy = 1'b0;
            while (!done && waited < 500) begin
                @(negedge clk);
                if (waited == 0) first_rdy = din_ready;
                if (din_ready) done = 1'b1;
                waited++;
                tick();
                do_control_packet = 1'b0;
            end
            ck($sformatf("din_handshake_beat%0d", i), 64'(done), 64'd1);
            if (typ == 4'hF && i > 0) ck($sformatf("drop_ready_beat%0d", i), 64'(first_rdy), 64'd1);
        end
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic check_out(input string tag);
        int t = 0;
        while ((rx_q.size() - rx_base) < exp_q.size() && t < 3000) begin
            tick();
            t++;
        end
        repeat (4) tick();
        ck({tag, "_beats"}, 64'(rx_q.size() - rx_base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (rx_base + i < rx_q.size())
                ck($sformatf("%s_beat%0d", tag, i), 64'(rx_q[rx_base + i]), 64'(exp_q[i]));
        end
        ck({tag, "_ctrl_sent"}, 64'(ctrl_pulses - pulse_base), 64'(exp_pulses));
        ck({tag, "_busy_idle"}, 64'(busy), 64'd0);
        rx_base    = rx_q.size();
        pulse_base = ctrl_pulses;
        exp_pulses = 0;
        exp_q.delete();
    endtask

    initial begin
        int lb;
        logic [3:0] typ;
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_data = '0;
        do_control_packet = 1'b0;
        width = '0; height = '0; interlaced = '0;
        m_pending = 1'b1; m_last = '0;

        #1;
        ck("rst_dout_valid", 64'(dout_valid), 64'd0);
        ck("rst_dout_sop",   64'(dout_sop),   64'd0);
        ck("rst_dout_eop",   64'(dout_eop),   64'd0);
        ck("rst_dout_data",  64'(dout_data),  64'd0);
        ck("rst_din_ready",  64'(din_ready),  64'd0);
        ck("rst_busy",       64'(busy),       64'd0);
        ck("rst_ctrl_sent",  64'(ctrl_sent),  64'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 640x480 interlace 3 with an explicit request.
        rdy_mode = 0;
        set_fmt(16'd640, 16'd480, 4'd3);
        request();
        lb = rx_base;
        send_pkt(4'h0, 4, 1'b0, 1'b0);
        check_out("frame1");
        ck("f1_hdr",   64'(rx_q[lb + 0]), 64'({1'b1, 1'b0, 24'h00000F}));
        ck("f1_body0", 64'(rx_q[lb + 1]), 64'({1'b0, 1'b0, 24'h080200}));
        ck("f1_body1", 64'(rx_q[lb + 2]), 64'({1'b0, 1'b0, 24'h010000}));
        ck("f1_body2", 64'(rx_q[lb + 3]), 64'({1'b0, 1'b1, 24'h03000E}));

        // Same format, toggling backpressure: no control packet expected.
        rdy_mode = 1;
        send_pkt(4'h0, 4, 1'b0, 1'b0);
        check_out("frame2");

        // Width change to 800 re-arms pending via change detection.
        set_fmt(16'd800, 16'd480, 4'd3);
        lb = rx_base;
        send_pkt(4'h0, 3, 1'b0, 1'b0);
        check_out("frame3");
        ck("f3_body0", 64'(rx_q[lb + 1]), 64'({1'b0, 1'b0, 24'h020300}));

        // Upstream control packet dropped, following video forwarded.
        rdy_mode = 2;
        send_pkt(4'hF, 3, 1'b0, 1'b0);
        send_pkt(4'h0, 2, 1'b0, 1'b1);
        check_out("drop");

        // Other packet types pass through; single-beat video frame.
        send_pkt(4'h5, 3, 1'b0, 1'b1);
        send_pkt(4'h0, 1, 1'b0, 1'b0);
        check_out("other_type");

        // Request coinciding with SEND_HDR entry keeps pending for next frame.
        rdy_mode = 0;
        set_fmt(16'd1024, 16'd768, 4'd0);
        send_pkt(4'h0, 2, 1'b1, 1'b0);
        check_out("req_entry1");
        send_pkt(4'h0, 2, 1'b0, 1'b0);
        check_out("req_entry2");

        // Reset while stalled in the control body.
        rdy_mode = 3;
        set_fmt(16'd320, 16'd240, 4'd1);
        tick();
        din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din_data = DW'(24'hABCD00);
        repeat (6) tick();
        ck("pre_rst_busy",  64'(busy),       64'd1);
        ck("pre_rst_valid", 64'(dout_valid), 64'd1);
        rst = 1'b1;
        #1;
        ck("mid_rst_valid", 64'(dout_valid), 64'd0);
        ck("mid_rst_busy",  64'(busy),       64'd0);
        din_valid = 1'b0; din_sop = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        m_pending = 1'b1; m_last = '0;
        exp_q.delete();
        rx_base = rx_q.size();
        pulse_base = ctrl_pulses;
        exp_pulses = 0;
        rdy_mode = 0;
        tick();
        send_pkt(4'h0, 3, 1'b0, 1'b0);
        check_out("post_reset");

        // Randomized traffic against the model.
        for (int it = 0; it < 25; it++) begin
            rdy_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 5))
                0: set_fmt(16'($urandom_range(1, 4) * 320), 16'($urandom_range(1, 3) * 240), 4'($urandom_range(0, 15)));
                1: request();
                default: tick();
            endcase
            case ($urandom_range(0, 4))
                0, 1, 2: typ = 4'h0;
                3:       typ = 4'hF;
                default: typ = 4'($urandom_range(1, 14));
            endcase
            send_pkt(typ, $urandom_range(1, 6), ($urandom_range(0, 5) == 0), 1'b1);
            check_out($sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
